dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 256x32 data RAM between the pipeline MEM stage (requester P) and an external program/data loader (requester L).
- Drives the RAM's address, data and write-enable pins. Stalls the pipeline when P loses arbitration.
- Fixed-priority arbitration favours P, with a starvation counter that guarantees L a slot.
- A loader-exclusive mode gives L the RAM for bulk loads, after draining any outstanding P read.

Parameters:
- ADDR_W, 8: RAM address width (word address).
- DATA_W, 32: data width.
- STARVE_LIMIT, 4: consecutive denied L-request cycles before L overrides P. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- p_req  in  1  P access request (MemRead | MemWrite).
- p_we  in  1  P write (1) / read (0).
- p_addr  in  ADDR_W  P word address (ALU result low bits).
- p_wdata  in  DATA_W  P store data.
- p_stall  out  1  P not granted this cycle; pipeline must hold EX/MEM.
- p_rvalid  out  1  P read data valid this cycle.
- p_rdata  out  DATA_W  P read data.
- l_req  in  1  L access request.
- l_we  in  1  L write/read.
- l_addr  in  ADDR_W  L address.
- l_wdata  in  DATA_W  L write data.
- l_excl  in  1  L requests exclusive ownership.
- l_gnt  out  1  L access accepted this cycle.
- l_excl_ack  out  1  exclusive mode active.
- l_rvalid  out  1  L read data valid.
- l_rdata  out  DATA_W  L read data.
- ram_address  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=NORMAL, starve_cnt=0, p_rvalid=0, l_rvalid=0, l_excl_ack=0.
  - While rst=0, all combinational outputs are forced to 0: p_stall, l_gnt, ram_wren, ram_address, ram_data.
  - A read in flight when reset is asserted is discarded; no rvalid follows.
- FSM states and transitions:
  - NORMAL: if l_excl=1, go to DRAIN.
  - DRAIN: lasts exactly 1 cycle. No grants; p_stall=p_req. Any outstanding rvalid completes. Then go to EXCL.
  - EXCL: l_excl_ack=1. L is granted on every l_req. p_stall=p_req. When l_excl=0, go to NORMAL.
- Arbitration in NORMAL (combinational, same cycle):
  - L wins (l_gnt=1, p_stall=p_req) when l_req=1 and (p_req=0 or starve_cnt==STARVE_LIMIT).
  - Otherwise P wins when p_req=1 (p_stall=0, l_gnt=0).
  - With no request: ram_wren=0 and ram_address holds the last granted address.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each cycle with l_req=1 and l_gnt=0 in NORMAL.
  - Clears on l_gnt=1 or when l_req=0.
  - Frozen in DRAIN and EXCL.
- RAM drive: the winner's addr/wdata go to ram_address/ram_data; ram_wren = winner's we & grant.
- Read return:
  - p_rvalid (or l_rvalid) is registered 1 for exactly one cycle after a granted read by that requester.
  - p_rdata/l_rdata = ram_q when the matching rvalid=1, else 0.
  - Latency is 1 cycle from grant to data.
  - Writes produce no rvalid.
- Simultaneous events:
  - l_excl rising in the same cycle as a P grant: that P access completes; DRAIN starts next cycle.
  - l_excl dropping in DRAIN: still enter EXCL for 1 cycle, then NORMAL.
- Back-to-back: a write followed by a read to the same address in consecutive cycles returns the new data (separate cycles; no bypass needed).

Test Plan:
1. Reset hold.
   - Stimulus: rst=0 for 3 cycles with p_req=1, l_req=1.
   - Required: p_stall=0, l_gnt=0, ram_wren=0, rvalid=0 throughout.
2. P only.
   - Stimulus: write 0xDEADBEEF to addr 0x10, then read 0x10.
   - Required: ram_wren=1 in cycle 0, p_stall=0; p_rvalid=1 with p_rdata=0xDEADBEEF in cycle 2.
3. Starvation with STARVE_LIMIT=4.
   - Stimulus: p_req and l_req both held high.
   - Required: P is granted for 4 cycles; the 5th cycle gives l_gnt=1 and p_stall=1; starve_cnt returns to 0; pattern repeats with period 5.
4. Exclusive load.
   - Stimulus: P read granted, l_excl raised in the same cycle.
   - Required: p_rvalid appears in the next (DRAIN) cycle; l_excl_ack=1 from the following cycle; L writes 0x00..0x03 with values 1..4 while p_stall=1.
   - Then drop l_excl; NORMAL follows one cycle later; P reads 0x02 and gets 3.
5. Reset mid-read.
   - Stimulus: L read granted, rst=0 on the next edge.
   - Required: l_rvalid never asserts; state=NORMAL after release.
6. Idle.
   - Stimulus: no requests for 10 cycles.
   - Required: ram_wren=0, starve_cnt=0, no stalls, no rvalid.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port RAM between the pipeline MEM stage (requester P) and
// an external loader (requester L).
//
// Arbitration rules:
//   - P normally has priority over L.
//   - A starvation counter makes sure L eventually gets a slot.
//   - In exclusive mode the RAM belongs to L. Entering that mode first drains
//     any P read that is still in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   p_req/p_we/p_addr/p_wdata   pipeline request; p_stall when not granted
//   p_rvalid/p_rdata    pipeline read return (one cycle after grant)
//   l_req/l_we/l_addr/l_wdata   loader request; l_gnt when accepted
//   l_excl/l_excl_ack   loader exclusive-ownership request / acknowledge
//   l_rvalid/l_rdata    loader read return (one cycle after grant)
//   ram_address/ram_data/ram_wren/ram_q   RAM pins (ram_q has 1-cycle latency)
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_excl,
  output logic              l_gnt,
  output logic              l_excl_ack,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_EXCL   = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  state_e              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                p_rvalid_q, p_rvalid_d;
  logic                l_rvalid_q, l_rvalid_d;
  logic                l_excl_ack_q, l_excl_ack_d;
  logic                p_win_s, l_win_s;

  // Same-cycle arbitration: decide which requester owns the RAM this cycle.
  always_comb begin
    p_win_s = 1'b0;
    l_win_s = 1'b0;
    if (!rst) begin
      p_win_s = 1'b0;
      l_win_s = 1'b0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          // L overrides P once it has been denied STARVE_LIMIT cycles in a row.
          if (l_req && (!p_req || (starve_q == LIMIT_C))) begin
            l_win_s = 1'b1;
          end else if (p_req) begin
            p_win_s = 1'b1;
          end else begin
            p_win_s = 1'b0;
          end
        end
        ST_DRAIN: begin
          // One empty cycle so that a P read already issued can return.
          p_win_s = 1'b0;
        end
        ST_EXCL: begin
          l_win_s = l_req;
        end
        default: begin
          p_win_s = 1'b0;
          l_win_s = 1'b0;
        end
      endcase
    end
  end

  // RAM pin drive and handshake outputs. Everything is forced low while in reset.
  always_comb begin
    ram_address = addr_q;
    ram_data    = data_q;
    ram_wren    = 1'b0;
    l_gnt       = l_win_s;
    p_stall     = rst & p_req & ~p_win_s;
    if (!rst) begin
      ram_address = '0;
      ram_data    = '0;
    end else if (l_win_s) begin
      ram_address = l_addr;
      ram_data    = l_wdata;
      ram_wren    = l_we;
    end else if (p_win_s) begin
      ram_address = p_addr;
      ram_data    = p_wdata;
      ram_wren    = p_we;
    end else begin
      // No grant: hold the address (and data) of the last granted access.
      ram_address = addr_q;
      ram_data    = data_q;
    end
  end

  // Next-state logic for the mode FSM, the starvation counter and the read returns.
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    addr_d       = ram_address;
    data_d       = ram_data;
    p_rvalid_d   = p_win_s & ~p_we;
    l_rvalid_d   = l_win_s & ~l_we;
    case (state_q)
      ST_NORMAL: begin
        if (l_excl) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_NORMAL;
        end
        if (l_req && !l_win_s) begin
          if (starve_q == LIMIT_C) begin
            starve_d = starve_q;
          end else begin
            starve_d = starve_q + 4'd1;
          end
        end else begin
          starve_d = 4'd0;
        end
      end
      ST_DRAIN: begin
        // The drain cycle always leads to EXCL, even if l_excl has already dropped.
        state_d = ST_EXCL;
      end
      ST_EXCL: begin
        if (!l_excl) begin
          state_d = ST_NORMAL;
        end else begin
          state_d = ST_EXCL;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
    l_excl_ack_d = (state_d == ST_EXCL);
  end

  // State registers. The synchronous reset also discards any read in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_NORMAL;
      starve_q     <= 4'd0;
      addr_q       <= '0;
      data_q       <= '0;
      p_rvalid_q   <= 1'b0;
      l_rvalid_q   <= 1'b0;
      l_excl_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      p_rvalid_q   <= p_rvalid_d;
      l_rvalid_q   <= l_rvalid_d;
      l_excl_ack_q <= l_excl_ack_d;
    end
  end

  assign p_rvalid   = p_rvalid_q;
  assign l_rvalid   = l_rvalid_q;
  assign l_excl_ack = l_excl_ack_q;
  assign p_rdata    = p_rvalid_q ? ram_q : '0;
  assign l_rdata    = l_rvalid_q ? ram_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// A behavioural RAM answers the DUT's RAM pins.
// A cycle-level reference model predicts every output from the arbitration rules.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_req = 1'b0, p_we = 1'b0, l_req = 1'b0, l_we = 1'b0, l_excl = 1'b0;
  logic [7:0]  p_addr = 8'h00, l_addr = 8'h00;
  logic [31:0] p_wdata = 32'h0, l_wdata = 32'h0;
  logic        p_stall, p_rvalid, l_gnt, l_excl_ack, l_rvalid, ram_wren;
  logic [31:0] p_rdata, l_rdata, ram_data;
  logic [31:0] ram_q = 32'h0;
  logic [7:0]  ram_address;
  logic [31:0] ram_mem [256] = '{default: 32'h0};

  int errs = 0;
  int checks = 0;

  // Reference model state.
  int          m_mode = 0;     // 0 normal, 1 drain, 2 exclusive
  int          m_denied = 0;
  logic [31:0] m_mem [256] = '{default: 32'h0};
  logic        m_p_pend = 1'b0, m_l_pend = 1'b0;
  logic [31:0] m_p_data = 32'h0, m_l_data = 32'h0;
  logic [7:0]  m_last_addr = 8'h00;

  // Predicted outputs for the current cycle.
  logic        e_pg, e_lg, e_pstall, e_wren, e_prv, e_lrv, e_ack;
  logic [7:0]  e_addr;
  logic [31:0] e_data, e_prd, e_lrd;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_excl(l_excl), .l_gnt(l_gnt), .l_excl_ack(l_excl_ack),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  task automatic predict();
    e_pg = 1'b0;
    e_lg = 1'b0;
    if (rst) begin
      if (m_mode == 0) begin
        if (l_req && (!p_req || m_denied >= LIMIT)) e_lg = 1'b1;
        else e_pg = p_req;
      end else if (m_mode == 2) begin
        e_lg = l_req;
      end
    end
    e_pstall = rst && p_req && !e_pg;
    e_wren   = (e_pg && p_we) || (e_lg && l_we);
    e_addr   = !rst ? 8'h00 : (e_lg ? l_addr : (e_pg ? p_addr : m_last_addr));
    e_data   = e_lg ? l_wdata : p_wdata;
    e_prv    = m_p_pend;
    e_prd    = m_p_pend ? m_p_data : 32'h0;
    e_lrv    = m_l_pend;
    e_lrd    = m_l_pend ? m_l_data : 32'h0;
    e_ack    = (m_mode == 2);
  endtask

  task automatic advance();
    if (!rst) begin
      m_mode = 0; m_denied = 0; m_p_pend = 1'b0; m_l_pend = 1'b0; m_last_addr = 8'h00;
    end else begin
      m_p_pend = e_pg && !p_we;
      if (m_p_pend) m_p_data = m_mem[p_addr];
      m_l_pend = e_lg && !l_we;
      if (m_l_pend) m_l_data = m_mem[l_addr];
      if (e_wren) m_mem[e_addr] = e_data;
      if (e_pg || e_lg) m_last_addr = e_addr;
      if (m_mode == 0) m_denied = (l_req && !e_lg) ? ((m_denied + 1 > LIMIT) ? LIMIT : m_denied + 1) : 0;
      if (m_mode == 0) m_mode = l_excl ? 1 : 0;
      else if (m_mode == 1) m_mode = 2;
      else m_mode = l_excl ? 2 : 0;
    end
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic clock();
    predict();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic idle_inputs();
    p_req = 1'b0; p_we = 1'b0; l_req = 1'b0; l_we = 1'b0; l_excl = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; p_req = 1'b1; l_req = 1'b1; p_we = 1'b1; l_we = 1'b1;
    clock();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (p_stall !== 1'b0) begin errs++; $display("FAIL reset_p_stall got=%b exp=0", p_stall); end
      checks++; if (l_gnt !== 1'b0) begin errs++; $display("FAIL reset_l_gnt got=%b exp=0", l_gnt); end
      checks++; if (ram_wren !== 1'b0) begin errs++; $display("FAIL reset_ram_wren got=%b exp=0", ram_wren); end
      checks++; if ((p_rvalid | l_rvalid) !== 1'b0) begin errs++; $display("FAIL reset_rvalid got=%b%b exp=00", p_rvalid, l_rvalid); end
      clock();
    end
    rst = 1'b1; idle_inputs();
    clock();
  endtask

  task automatic test_p_only();
    p_req = 1'b1; p_we = 1'b1; p_addr = 8'h10; p_wdata = 32'hDEADBEEF;
    settle();
    checks++; if (ram_wren !== 1'b1 || p_stall !== 1'b0) begin errs++; $display("FAIL ponly_write got wren=%b stall=%b exp wren=1 stall=0", ram_wren, p_stall); end
    checks++; if (ram_address !== 8'h10 || ram_data !== 32'hDEADBEEF) begin errs++; $display("FAIL ponly_pins got=%h/%h exp=10/deadbeef", ram_address, ram_data); end
    clock();
    p_we = 1'b0;
    settle();
    checks++; if (ram_wren !== 1'b0 || p_stall !== 1'b0) begin errs++; $display("FAIL ponly_read got wren=%b stall=%b exp 0 0", ram_wren, p_stall); end
    clock();
    p_req = 1'b0;
    settle();
    checks++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL ponly_rdata got=%b/%h exp=1/deadbeef", p_rvalid, p_rdata); end
    clock();
    settle();
    checks++; if (p_rvalid !== 1'b0 || p_rdata !== 32'h0) begin errs++; $display("FAIL ponly_rvalid_once got=%b/%h exp=0/0", p_rvalid, p_rdata); end
    clock();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++; if ({ram_wren, p_stall, l_gnt, p_rvalid, l_rvalid} !== 5'b0) begin errs++; $display("FAIL idle got=%b exp=00000", {ram_wren, p_stall, l_gnt, p_rvalid, l_rvalid}); end
      checks++; if (ram_address !== 8'h10) begin errs++; $display("FAIL idle_addr_hold got=%h exp=10", ram_address); end
      clock();
    end
  endtask

  task automatic test_starvation();
    idle_inputs();
    clock();
    for (int i = 0; i < 10; i++) begin
      p_req = 1'b1; p_we = 1'b0; p_addr = 8'(i);
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'(8'h40 + i); l_wdata = 32'(i);
      settle();
      checks++; if (l_gnt !== ((i % 5) == 4)) begin errs++; $display("FAIL starve_l_gnt cyc=%0d got=%b exp=%b", i, l_gnt, (i % 5) == 4); end
      checks++; if (p_stall !== ((i % 5) == 4)) begin errs++; $display("FAIL starve_p_stall cyc=%0d got=%b exp=%b", i, p_stall, (i % 5) == 4); end
      clock();
    end
    idle_inputs();
    clock();
  endtask

  task automatic test_excl();
    idle_inputs();
    p_req = 1'b1; p_we = 1'b1; p_addr = 8'h20; p_wdata = 32'h12345678;
    clock();
    p_we = 1'b0; l_excl = 1'b1;
    settle();
    checks++; if (p_stall !== 1'b0 || l_excl_ack !== 1'b0) begin errs++; $display("FAIL excl_pgrant got stall=%b ack=%b exp 0 0", p_stall, l_excl_ack); end
    clock();
    p_addr = 8'h21; l_req = 1'b1; l_we = 1'b1; l_addr = 8'h00; l_wdata = 32'd1;
    settle();
    checks++; if (p_rvalid !== 1'b1 || p_rdata !== 32'h12345678) begin errs++; $display("FAIL excl_drain_rdata got=%b/%h exp=1/12345678", p_rvalid, p_rdata); end
    checks++; if (p_stall !== 1'b1 || l_gnt !== 1'b0 || l_excl_ack !== 1'b0) begin errs++; $display("FAIL excl_drain got stall=%b gnt=%b ack=%b exp 1 0 0", p_stall, l_gnt, l_excl_ack); end
    clock();
    for (int i = 0; i < 4; i++) begin
      l_addr = 8'(i); l_wdata = 32'(i + 1);
      settle();
      checks++; if (l_excl_ack !== 1'b1 || l_gnt !== 1'b1 || p_stall !== 1'b1) begin errs++; $display("FAIL excl_load cyc=%0d got ack=%b gnt=%b stall=%b exp 1 1 1", i, l_excl_ack, l_gnt, p_stall); end
      checks++; if (ram_wren !== 1'b1 || ram_address !== 8'(i)) begin errs++; $display("FAIL excl_pins cyc=%0d got wren=%b addr=%h exp 1 %h", i, ram_wren, ram_address, 8'(i)); end
      clock();
    end
    l_excl = 1'b0; l_req = 1'b0; p_addr = 8'h02;
    settle();
    checks++; if (l_excl_ack !== 1'b1 || p_stall !== 1'b1) begin errs++; $display("FAIL excl_last got ack=%b stall=%b exp 1 1", l_excl_ack, p_stall); end
    clock();
    settle();
    checks++; if (l_excl_ack !== 1'b0 || p_stall !== 1'b0) begin errs++; $display("FAIL excl_back_normal got ack=%b stall=%b exp 0 0", l_excl_ack, p_stall); end
    clock();
    p_req = 1'b0;
    settle();
    checks++; if (p_rvalid !== 1'b1 || p_rdata !== 32'd3) begin errs++; $display("FAIL excl_readback got=%b/%h exp=1/3", p_rvalid, p_rdata); end
    clock();
  endtask

  task automatic test_reset_midread();
    idle_inputs();
    l_req = 1'b1; l_addr = 8'h02;
    settle();
    checks++; if (l_gnt !== 1'b1) begin errs++; $display("FAIL rstmid_grant got=%b exp=1", l_gnt); end
    rst = 1'b0;
    settle();
    checks++; if (l_gnt !== 1'b0 || ram_address !== 8'h00) begin errs++; $display("FAIL rstmid_forced got gnt=%b addr=%h exp 0 00", l_gnt, ram_address); end
    clock();
    settle();
    checks++; if (l_rvalid !== 1'b0) begin errs++; $display("FAIL rstmid_rvalid got=%b exp=0", l_rvalid); end
    clock();
    rst = 1'b1; l_req = 1'b0;
    settle();
    checks++; if (l_rvalid !== 1'b0 || l_excl_ack !== 1'b0) begin errs++; $display("FAIL rstmid_after got rvalid=%b ack=%b exp 0 0", l_rvalid, l_excl_ack); end
    p_req = 1'b1; l_req = 1'b1;
    settle();
    checks++; if (p_stall !== 1'b0 || l_gnt !== 1'b0) begin errs++; $display("FAIL rstmid_normal got stall=%b gnt=%b exp 0 0", p_stall, l_gnt); end
    clock();
    idle_inputs();
    clock();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 99) != 0);
      p_req   = ($urandom_range(0, 9) < 7);
      p_we    = ($urandom_range(0, 1) == 1);
      p_addr  = 8'($urandom_range(0, 15));
      p_wdata = $urandom;
      l_req   = ($urandom_range(0, 1) == 1);
      l_we    = ($urandom_range(0, 1) == 1);
      l_addr  = 8'($urandom_range(0, 15));
      l_wdata = $urandom;
      if ($urandom_range(0, 19) == 0) l_excl = ~l_excl;
      settle();
      checks++; if (p_stall !== e_pstall) begin errs++; $display("FAIL rnd_p_stall cyc=%0d got=%b exp=%b", c, p_stall, e_pstall); end
      checks++; if (l_gnt !== e_lg) begin errs++; $display("FAIL rnd_l_gnt cyc=%0d got=%b exp=%b", c, l_gnt, e_lg); end
      checks++; if (ram_wren !== e_wren) begin errs++; $display("FAIL rnd_ram_wren cyc=%0d got=%b exp=%b", c, ram_wren, e_wren); end
      checks++; if (ram_address !== e_addr) begin errs++; $display("FAIL rnd_ram_address cyc=%0d got=%h exp=%h", c, ram_address, e_addr); end
      if (e_pg || e_lg) begin
        checks++; if (ram_data !== e_data) begin errs++; $display("FAIL rnd_ram_data cyc=%0d got=%h exp=%h", c, ram_data, e_data); end
      end
      checks++; if (p_rvalid !== e_prv || p_rdata !== e_prd) begin errs++; $display("FAIL rnd_p_read cyc=%0d got=%b/%h exp=%b/%h", c, p_rvalid, p_rdata, e_prv, e_prd); end
      checks++; if (l_rvalid !== e_lrv || l_rdata !== e_lrd) begin errs++; $display("FAIL rnd_l_read cyc=%0d got=%b/%h exp=%b/%h", c, l_rvalid, l_rdata, e_lrv, e_lrd); end
      checks++; if (l_excl_ack !== e_ack) begin errs++; $display("FAIL rnd_excl_ack cyc=%0d got=%b exp=%b", c, l_excl_ack, e_ack); end
      clock();
    end
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_idle();
    test_starvation();
    test_excl();
    test_reset_midread();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
